// File: rtl/chirp_cmd_sequencer.sv
// chirp_cmd_sequencer
//   Command front-end for the chirp generator. It parses framed UART bytes
//   (0xA5, CMD, ARG, DAT, CHK with CHK = CMD ^ ARG ^ DAT) into config-register
//   writes and run/abort/clear commands. It then sequences N back-to-back chirps:
//   it issues a start pulse and waits for the generator's active-low done strobe.
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_rx_valid, i_rx_data one-cycle received-byte strobe and byte
//   o_wr_en/addr/data     one-cycle config register write
//   o_start               one-cycle chirp start pulse
//   i_done_n              generator done, active low
//   o_busy                high while a run is in progress
//   o_err                 sticky error; cleared by a valid CLR frame or reset
module chirp_cmd_sequencer #(
    parameter int unsigned ADDR_WIDTH     = 6,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 20000,
    parameter int unsigned GAP_CYCLES     = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rx_valid,
    input  logic [7:0]            i_rx_data,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_start,
    input  logic                  i_done_n,
    output logic                  o_busy,
    output logic                  o_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    localparam logic [2:0] P_SYNC = 3'd0;
    localparam logic [2:0] P_CMD  = 3'd1;
    localparam logic [2:0] P_ARG  = 3'd2;
    localparam logic [2:0] P_DAT  = 3'd3;
    localparam logic [2:0] P_CHK  = 3'd4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_RUN   = 8'h02;
    localparam logic [7:0] CMD_ABORT = 8'h03;
    localparam logic [7:0] CMD_CLR   = 8'h04;

    logic [2:0]            p_state_q, p_state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0] arg_q, arg_d;
    logic [7:0]            dat_q, dat_d;
    logic [7:0]            chk_acc_q, chk_acc_d;
    logic                  exec_q, exec_d;
    logic                  chk_ok_q, chk_ok_d;
    logic [1:0]            seq_state_q, seq_state_d;
    logic [7:0]            count_q, count_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic                  err_q, err_d;
    logic                  timeout;

    logic seq_idle, exec_ok, is_write, is_run, is_abort;

    // Frame parser with inter-byte timeout. A completed frame is latched and
    // executed in the following cycle (exec_q).
    always_comb begin
        p_state_d = p_state_q;
        timer_d   = timer_q;
        cmd_d     = cmd_q;
        arg_d     = arg_q;
        dat_d     = dat_q;
        chk_acc_d = chk_acc_q;
        chk_ok_d  = chk_ok_q;
        exec_d    = 1'b0;
        timeout   = 1'b0;
        if (p_state_q != P_SYNC) begin
            timer_d = timer_q + 1'b1;
        end
        if (i_rx_valid) begin
            timer_d = '0;
            case (p_state_q)
                P_SYNC: begin
                    if (i_rx_data == SYNC_BYTE) begin
                        p_state_d = P_CMD;
                    end
                end
                P_CMD: begin
                    cmd_d     = i_rx_data;
                    chk_acc_d = i_rx_data;
                    p_state_d = P_ARG;
                end
                P_ARG: begin
                    arg_d     = i_rx_data[ADDR_WIDTH-1:0];
                    chk_acc_d = chk_acc_q ^ i_rx_data;
                    p_state_d = P_DAT;
                end
                P_DAT: begin
                    dat_d     = i_rx_data;
                    chk_acc_d = chk_acc_q ^ i_rx_data;
                    p_state_d = P_CHK;
                end
                P_CHK: begin
                    chk_ok_d  = (i_rx_data == chk_acc_q);
                    exec_d    = 1'b1;
                    p_state_d = P_SYNC;
                end
                default: p_state_d = P_SYNC;
            endcase
        end else if (p_state_q != P_SYNC && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout   = 1'b1;
            timer_d   = '0;
            p_state_d = P_SYNC;
        end
    end

    assign seq_idle = (seq_state_q == S_IDLE);
    assign exec_ok  = exec_q && chk_ok_q;
    assign is_write = exec_ok && (cmd_q == CMD_WRITE);
    assign is_run   = exec_ok && (cmd_q == CMD_RUN);
    assign is_abort = exec_ok && (cmd_q == CMD_ABORT);

    // Sticky error flag.
    always_comb begin
        err_d = err_q;
        if (timeout) begin
            err_d = 1'b1;
        end
        if (exec_q) begin
            if (!chk_ok_q) begin
                err_d = 1'b1;
            end else begin
                case (cmd_q)
                    CMD_WRITE: if (!seq_idle) err_d = 1'b1;
                    CMD_RUN:   if (!seq_idle) err_d = 1'b1;
                    CMD_ABORT: err_d = err_q;
                    CMD_CLR:   err_d = 1'b0;
                    default:   err_d = 1'b1;
                endcase
            end
        end
    end

    // Chirp sequencer.
    always_comb begin
        seq_state_d = seq_state_q;
        count_d     = count_q;
        gap_d       = gap_q;
        case (seq_state_q)
            S_IDLE: begin
                if (is_run && dat_q != 8'd0) begin
                    seq_state_d = S_START;
                    count_d     = dat_q;
                end
            end
            S_START: seq_state_d = S_WAIT;
            S_WAIT: begin
                if (!i_done_n) begin
                    count_d = count_q - 8'd1;
                    if (count_q == 8'd1) begin
                        seq_state_d = S_IDLE;
                    end else begin
                        seq_state_d = S_GAP;
                        gap_d       = '0;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    seq_state_d = S_START;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: seq_state_d = S_IDLE;
        endcase
        // Abort overrides everything, including a done sampled this cycle.
        if (is_abort) begin
            seq_state_d = S_IDLE;
            count_d     = 8'd0;
            gap_d       = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            p_state_q   <= P_SYNC;
            timer_q     <= '0;
            cmd_q       <= 8'd0;
            arg_q       <= '0;
            dat_q       <= 8'd0;
            chk_acc_q   <= 8'd0;
            chk_ok_q    <= 1'b0;
            exec_q      <= 1'b0;
            seq_state_q <= S_IDLE;
            count_q     <= 8'd0;
            gap_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            p_state_q   <= p_state_d;
            timer_q     <= timer_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            dat_q       <= dat_d;
            chk_acc_q   <= chk_acc_d;
            chk_ok_q    <= chk_ok_d;
            exec_q      <= exec_d;
            seq_state_q <= seq_state_d;
            count_q     <= count_d;
            gap_q       <= gap_d;
            err_q       <= err_d;
        end
    end

    assign o_wr_en   = is_write && seq_idle;
    assign o_wr_addr = arg_q;
    assign o_wr_data = DATA_WIDTH'(dat_q);
    assign o_start   = (seq_state_q == S_START);
    assign o_busy    = !seq_idle;
    assign o_err     = err_q;

endmodule

// File: tb/tb_chirp_cmd_sequencer.sv
// Scoreboard bench for chirp_cmd_sequencer: expected writes/starts are queued
// as frames are sent, and a monitor pops and compares on each o_wr_en/o_start.
module tb_chirp_cmd_sequencer;

    localparam int unsigned TO  = 100;
    localparam int unsigned GAP = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       done_n;
    logic       busy;
    logic       err;

    always #5 clk = ~clk;

    chirp_cmd_sequencer #(
        .ADDR_WIDTH    (6),
        .DATA_WIDTH    (8),
        .TIMEOUT_CYCLES(TO),
        .GAP_CYCLES    (GAP)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_rx_valid(rx_valid),
        .i_rx_data (rx_data),
        .o_wr_en   (wr_en),
        .o_wr_addr (wr_addr),
        .o_wr_data (wr_data),
        .o_start   (start),
        .i_done_n  (done_n),
        .o_busy    (busy),
        .o_err     (err)
    );

    typedef struct packed {
        logic       is_write;
        logic [5:0] addr;
        logic [7:0] data;
        logic       after_done;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_done_cyc = -1000;
    int   starts_seen = 0;
    int   done_cnt = 0;
    bit   auto_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!done_n) last_done_cyc = cyc;
            if (wr_en || start) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {30'd0, wr_en, start}, 32'd0);
                    if (start) starts_seen++;
                end else begin
                    e = exp_q.pop_front();
                    check("out_kind_is_write", {31'd0, wr_en}, {31'd0, e.is_write});
                    if (e.is_write) begin
                        check("wr_addr", {26'd0, wr_addr}, {26'd0, e.addr});
                        check("wr_data", {24'd0, wr_data}, {24'd0, e.data});
                    end else begin
                        starts_seen++;
                        if (e.after_done)
                            check("start_gap_ge", {31'd0, (cyc - last_done_cyc) >= GAP}, 32'd1);
                    end
                end
            end
        end
    end

    // Generator model: done_n low for 2 cycles, 4 cycles after each start.
    initial begin
        forever begin
            @(negedge clk);
            if (start && auto_done) begin
                repeat (4) @(posedge clk);
                #1 done_n = 1'b0;
                repeat (2) @(posedge clk);
                #1 done_n = 1'b1;
                done_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1 rx_valid = 1'b1;
        rx_data = b;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    // Ends #1 after the edge that sampled CHK, i.e. inside the execute cycle.
    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] k);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(a);
        send_byte(d);
        @(posedge clk);
        #1 rx_valid = 1'b1;
        rx_data = k;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic push_write(input logic [5:0] a, input logic [7:0] d);
        exp_t e;
        e.is_write = 1'b1; e.addr = a; e.data = d; e.after_done = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_start(input logic after_done);
        exp_t e;
        e.is_write = 1'b0; e.addr = '0; e.data = '0; e.after_done = after_done;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int max);
        for (int i = 0; i < max && busy; i++) @(posedge clk);
        #1;
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic clear_err(input string name);
        send_frame(8'h04, 8'h00, 8'h00, 8'h04);
        wait_cycles(3);
        check(name, {31'd0, err}, 32'd0);
    endtask

    int base;

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; done_n = 1'b1;
        #1;
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_start", {31'd0, start}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(2);

        // WRITE, then one-cycle latency and address truncation
        push_write(6'h05, 8'h3C);
        send_frame(8'h01, 8'h05, 8'h3C, 8'h38);
        check("t1_wr_latency", {31'd0, wr_en}, 32'd1);
        wait_cycles(3);
        check("t1_err", {31'd0, err}, 32'd0);
        push_write(6'h05, 8'h7E);
        send_frame(8'h01, 8'h45, 8'h7E, 8'h3A);
        wait_cycles(3);

        // RUN n=3
        auto_done = 1'b1;
        base = starts_seen;
        push_start(1'b0); push_start(1'b1); push_start(1'b1);
        send_frame(8'h02, 8'h00, 8'h03, 8'h01);
        check("t2_start_not_yet", {31'd0, start}, 32'd0);
        wait_cycles(1);
        check("t2_start_latency", {31'd0, start}, 32'd1);
        check("t2_busy", {31'd0, busy}, 32'd1);
        wait_idle("t2_idle_timeout", 400);
        check("t2_start_count", starts_seen - base, 32'd3);
        check("t2_err", {31'd0, err}, 32'd0);
        wait_cycles(5);

        // RUN n=0 is a no-op
        send_frame(8'h02, 8'h00, 8'h00, 8'h02);
        wait_cycles(4);
        check("run0_busy", {31'd0, busy}, 32'd0);
        check("run0_err", {31'd0, err}, 32'd0);

        // RUN n=10, ABORT after the 2nd done
        base = done_cnt;
        push_start(1'b0); push_start(1'b1);
        send_frame(8'h02, 8'h00, 8'h0A, 8'h08);
        for (int i = 0; i < 200 && done_cnt < base + 2; i++) @(posedge clk);
        #1;
        check("t3_two_dones", done_cnt - base, 32'd2);
        send_frame(8'h03, 8'h00, 8'h00, 8'h03);
        wait_cycles(1);
        check("t3_busy_after_abort", {31'd0, busy}, 32'd0);
        wait_cycles(80);
        check("t3_busy_late", {31'd0, busy}, 32'd0);
        check("t3_pending", exp_q.size(), 32'd0);
        check("t3_err", {31'd0, err}, 32'd0);

        // Bad checksum, then CLR
        send_frame(8'h01, 8'h05, 8'h3C, 8'h00);
        wait_cycles(3);
        check("t4_badchk_err", {31'd0, err}, 32'd1);
        clear_err("t4_clr");

        // Unknown command
        send_frame(8'h07, 8'h00, 8'h00, 8'h07);
        wait_cycles(3);
        check("badcmd_err", {31'd0, err}, 32'd1);
        clear_err("badcmd_clr");

        // Inter-byte timeout, then a full frame still executes
        send_byte(8'hA5);
        send_byte(8'h01);
        wait_cycles(TO + 10);
        check("t5_timeout_err", {31'd0, err}, 32'd1);
        clear_err("t5_clr");
        push_write(6'h2A, 8'h99);
        send_frame(8'h01, 8'h2A, 8'h99, 8'hB2);
        wait_cycles(3);
        check("t5_pending", exp_q.size(), 32'd0);

        // WRITE and RUN while busy, then reset mid-run
        auto_done = 1'b0;
        base = starts_seen;
        push_start(1'b0);
        send_frame(8'h02, 8'h00, 8'h03, 8'h01);
        wait_cycles(3);
        check("t6_busy", {31'd0, busy}, 32'd1);
        send_frame(8'h01, 8'h05, 8'h3C, 8'h38);
        wait_cycles(3);
        check("t6_write_busy_err", {31'd0, err}, 32'd1);
        clear_err("t6_clr");
        send_frame(8'h02, 8'h00, 8'h05, 8'h07);
        wait_cycles(3);
        check("t6_run_busy_err", {31'd0, err}, 32'd1);
        check("t6_still_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_err", {31'd0, err}, 32'd0);
        check("t6_rst_start", {31'd0, start}, 32'd0);
        check("t6_rst_wr_en", {31'd0, wr_en}, 32'd0);
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(40);
        check("t6_post_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_start_count", starts_seen - base, 32'd1);
        check("final_pending", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
